// File: rtl/maxbw_pkg.sv
// Shared definitions for the maxbw DDR pin link, used by both the transmit and capture sides.
package maxbw_pkg;

  localparam int DEFAULT_PIN_W = 8;
  localparam int DEFAULT_WORD_W = 2 * DEFAULT_PIN_W;
  localparam logic [DEFAULT_PIN_W-1:0] IDLE_BYTE = 8'h00;

  // A word as it crosses the pins: lo goes out in the clk-high phase, hi in the clk-low phase.
  typedef struct packed {
    logic [DEFAULT_PIN_W-1:0] hi;
    logic [DEFAULT_PIN_W-1:0] lo;
  } ddr_word_t;

endpackage

// File: rtl/maxbw_sync_fifo.sv
// Small synchronous FIFO with registered storage and an occupancy counter one bit wider than the pointers.
module maxbw_sync_fifo
  import maxbw_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [WORD_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is just natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/maxbw_ddr_tx.sv
// Transmit side of the maxbw DDR pin link: FIFO-buffered 16-bit words driven out as two bytes per clk.
module maxbw_ddr_tx
  import maxbw_pkg::*;
#(
  parameter int PIN_W = DEFAULT_PIN_W,
  parameter int DEPTH = 4,
  parameter logic [PIN_W-1:0] IDLE = IDLE_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*PIN_W-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     enable,
  output logic [PIN_W-1:0]         ddr_out,
  output logic                     ddr_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               underrun_cnt
);

  logic [2*PIN_W-1:0] head;
  logic [PIN_W-1:0]   out_lo;
  logic [PIN_W-1:0]   out_hi;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               armed;

  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  // Pop decision uses the registered level only: a word always spends one cycle in the FIFO.
  assign pop      = enable && !empty;

  maxbw_sync_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (2 * PIN_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_lo       <= IDLE;
      out_hi       <= IDLE;
      ddr_valid    <= 1'b0;
      armed        <= 1'b0;
      underrun_cnt <= 8'h00;
    end else begin
      if (pop) begin
        out_lo    <= head[PIN_W-1:0];
        out_hi    <= head[2*PIN_W-1:PIN_W];
        ddr_valid <= 1'b1;
        armed     <= 1'b1;
      end else begin
        out_lo    <= IDLE;
        out_hi    <= IDLE;
        ddr_valid <= 1'b0;
      end
      if (armed && enable && empty && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'h01;
      end
    end
  end

  // The only place clk is used as data; keep out_lo/out_hi placed next to this mux.
  assign ddr_out = clk ? out_lo : out_hi;

endmodule

// File: tb/tb_maxbw_ddr_tx.sv
// Scoreboard bench for maxbw_ddr_tx: stimulus queues expected words, a pin monitor pops and checks them.
module tb_maxbw_ddr_tx;
  import maxbw_pkg::*;

  localparam int PIN_W = 8;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [2*PIN_W-1:0]     in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   enable;
  logic [PIN_W-1:0]       ddr_out;
  logic                   ddr_valid;
  logic [$clog2(DEPTH):0] level;
  logic [7:0]             underrun_cnt;

  int        n_compared = 0;
  int        n_mismatched = 0;
  logic      mon_on = 1'b0;
  ddr_word_t exp_q[$];

  maxbw_ddr_tx #(
    .PIN_W (PIN_W),
    .DEPTH (DEPTH),
    .IDLE  (8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .enable       (enable),
    .ddr_out      (ddr_out),
    .ddr_valid    (ddr_valid),
    .level        (level),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data, input logic en);
    in_valid = valid;
    in_data  = data;
    enable   = en;
  endtask

  task automatic queueWord(input logic [15:0] w);
    ddr_word_t e;
    e = ddr_word_t'(w);
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("level after reset", 32'(level), 32'd0);
    checkOutput("underrun after reset", 32'(underrun_cnt), 32'd0);
    checkOutput("ddr_valid after reset", 32'(ddr_valid), 32'd0);
  endtask

  // Pin monitor: lo byte in the clk-high phase, hi byte in the clk-low phase.
  initial begin
    ddr_word_t e;
    wait (mon_on);
    forever begin
      @(posedge clk);
      #1;
      if (ddr_valid) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected word: got lo %0h, expected no word", ddr_out);
          @(negedge clk);
          #1;
        end else begin
          e = exp_q.pop_front();
          checkOutput("word lo byte", 32'(ddr_out), 32'(e.lo));
          @(negedge clk);
          #1;
          checkOutput("word hi byte", 32'(ddr_out), 32'(e.hi));
        end
      end else begin
        checkOutput("idle lo phase", 32'(ddr_out), 32'h00);
        @(negedge clk);
        #1;
        checkOutput("idle hi phase", 32'(ddr_out), 32'h00);
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0);

    // Two reset cycles.
    tick();
    checkOutput("in_ready in rst", 32'(in_ready), 32'd0);
    checkOutput("level in rst", 32'(level), 32'd0);
    checkOutput("underrun in rst", 32'(underrun_cnt), 32'd0);
    checkOutput("ddr_valid in rst", 32'(ddr_valid), 32'd0);
    checkOutput("rst pins clk high", 32'(ddr_out), 32'h00);
    @(negedge clk);
    #1;
    checkOutput("rst pins clk low", 32'(ddr_out), 32'h00);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("in_ready after rst", 32'(in_ready), 32'd1);
    mon_on = 1'b1;

    // Single word, then starve the armed stream to exercise the underrun counter.
    applyStimulus(1'b1, 16'hA55A, 1'b1);
    queueWord(16'hA55A);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    checkOutput("level one word", 32'(level), 32'd1);
    tick();
    checkOutput("ddr_valid single", 32'(ddr_valid), 32'd1);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("underrun 10", 32'(underrun_cnt), 32'd10);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("underrun frozen", 32'(underrun_cnt), 32'd10);
    enable = 1'b1;
    for (int i = 0; i < 245; i++) tick();
    checkOutput("underrun 255", 32'(underrun_cnt), 32'hFF);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("underrun saturated", 32'(underrun_cnt), 32'hFF);
    enable = 1'b0;
    doReset();

    // Fill to full with enable low, then release the burst.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 16'(i * 16'h0101), 1'b0);
      queueWord(16'(i * 16'h0101));
      tick();
    end
    checkOutput("level full", 32'(level), 32'd4);
    checkOutput("in_ready full", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 16'h0505, 1'b1);
    queueWord(16'h0505);
    tick();
    checkOutput("burst valid 1", 32'(ddr_valid), 32'd1);
    checkOutput("in_ready after pop", 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      checkOutput($sformatf("burst valid %0d", i), 32'(ddr_valid), 32'd1);
      if (i < 5) tick();
    end
    tick();
    checkOutput("burst done valid", 32'(ddr_valid), 32'd0);
    checkOutput("burst done level", 32'(level), 32'd0);

    // Steady push+pop at level 2.
    applyStimulus(1'b1, 16'h2001, 1'b0);
    queueWord(16'h2001);
    tick();
    applyStimulus(1'b1, 16'h2002, 1'b0);
    queueWord(16'h2002);
    tick();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 16'h3000 + 16'(i), 1'b1);
      queueWord(16'h3000 + 16'(i));
      tick();
      checkOutput($sformatf("steady level %0d", i), 32'(level), 32'd2);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("steady drained", 32'(level), 32'd0);

    // Reset while streaming with three words queued.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'hC0C1 + 16'(i * 16'h0202), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("level 3", 32'(level), 32'd3);
    enable = 1'b1;
    queueWord(16'hC0C1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst level", 32'(level), 32'd0);
    checkOutput("midrst ddr_valid", 32'(ddr_valid), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("midrst stays empty", 32'(level), 32'd0);
    checkOutput("midrst no underrun", 32'(underrun_cnt), 32'd0);
    enable = 1'b0;

    tick();
    tick();
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
